fnd_digit_scanner: RTL

- Consumes the divided FND scan clock and time-multiplexes a NUM_DIGITS-digit hex value onto a common-anode 7-segment display.
- Sits directly downstream of the FND clock divider inside the FndController IP.
- Samples the scan clock as data in the system clock domain; it is never used as a clock.
- Drives active-low digit anodes and segments, with a per-frame shadow latch (no tearing) and anti-ghosting blank time.

---
 rtl/fnd_digit_scanner.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/fnd_digit_scanner.sv
// fnd_digit_scanner: time-multiplexes a NUM_DIGITS-digit hex value onto a
// common-anode 7-segment display.
// - The divided scan clock is sampled as data; it is never used as a clock.
// - A per-frame shadow latch prevents tearing.
// - Blank time after each digit change suppresses ghosting.
// Optional build macro: FND_LEADING_ZERO_BLANK_EN (suppress leading zero digits).
module fnd_digit_scanner #(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned BLANK_CYCLES = 4
) (
   input  logic                      i_clk,
   input  logic                      i_reset_n,
   input  logic                      i_clk_fnd,
   input  logic                      i_enable,
   input  logic [4*NUM_DIGITS-1:0]   i_value,
   input  logic [NUM_DIGITS-1:0]     i_dp,
   output logic [NUM_DIGITS-1:0]     o_an,
   output logic [7:0]                o_seg,
   output logic                      o_frame_done
);

   localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned BLK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES + 1) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
   localparam logic [BLK_W-1:0] BLANK_LOAD = BLK_W'(BLANK_CYCLES);

   logic                    sync_s1_q, sync_s2_q, sync_prev_q;
   logic                    tick_c;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [BLK_W-1:0]        blank_q, blank_d;
   logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d;
   logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
   logic [NUM_DIGITS-1:0]   an_d;
   logic [7:0]              seg_d;
   logic                    frame_d;

   // Active-low segment pattern {g,f,e,d,c,b,a} for a hex nibble
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   // Two-flop synchroniser plus previous-value flop for rising-edge detection
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         sync_s1_q   <= 1'b0;
         sync_s2_q   <= 1'b0;
         sync_prev_q <= 1'b0;
      end else begin
         sync_s1_q   <= i_clk_fnd;
         sync_s2_q   <= sync_s1_q;
         sync_prev_q <= sync_s2_q;
      end
   end

   assign tick_c = sync_s2_q & ~sync_prev_q;

   // Next-state for index, blank counter, shadow, and registered display outputs
   always_comb begin
      logic            show;
      logic            wrap;
      logic            dp_sel;
      logic            sup_sel;
      logic            upper_zero;
      logic [3:0]      nib_sel;
      logic [NUM_DIGITS-1:0] onehot;

      idx_d        = idx_q;
      blank_d      = blank_q;
      shadow_val_d = shadow_val_q;
      shadow_dp_d  = shadow_dp_q;
      frame_d      = 1'b0;
      an_d         = '1;
      seg_d        = 8'hFF;
      show         = 1'b0;
      wrap         = 1'b0;
      dp_sel       = 1'b0;
      sup_sel      = 1'b0;
      upper_zero   = 1'b1;
      nib_sel      = 4'h0;
      onehot       = '0;

      if (!i_enable) begin
         // Disabled: park on digit 0 and keep the shadow tracking the inputs
         idx_d        = '0;
         blank_d      = '0;
         shadow_val_d = i_value;
         shadow_dp_d  = i_dp;
      end else if (tick_c) begin
         wrap    = (idx_q == LAST_IDX);
         idx_d   = wrap ? '0 : idx_q + IDX_W'(1);
         blank_d = BLANK_LOAD;
         frame_d = wrap;
         if (wrap) begin
            shadow_val_d = i_value;
            shadow_dp_d  = i_dp;
         end
         // With no blank time the new anode switches on the advance edge
         show = (blank_d == '0);
      end else if (blank_q != '0) begin
         blank_d = blank_q - BLK_W'(1);
      end else begin
         show = 1'b1;
      end

      // Select the digit being driven next cycle
      for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
         upper_zero = upper_zero & (shadow_val_d[4*k +: 4] == 4'h0);
         if (idx_d == IDX_W'(k)) begin
            nib_sel   = shadow_val_d[4*k +: 4];
            dp_sel    = shadow_dp_d[k];
            onehot[k] = 1'b1;
`ifdef FND_LEADING_ZERO_BLANK_EN
            // Leading zeros go dark unless the dp is lit; digit 0 always shows
            sup_sel   = upper_zero & ~shadow_dp_d[k] & (k != 0);
`else
            sup_sel   = 1'b0;
`endif
         end
      end

      if (show && !sup_sel) begin
         an_d  = ~onehot;
         seg_d = {~dp_sel, hex_to_seg(nib_sel)};
      end
   end

   // State and output registers
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         idx_q        <= '0;
         blank_q      <= '0;
         shadow_val_q <= '0;
         shadow_dp_q  <= '0;
         o_an         <= '1;
         o_seg        <= 8'hFF;
         o_frame_done <= 1'b0;
      end else begin
         idx_q        <= idx_d;
         blank_q      <= blank_d;
         shadow_val_q <= shadow_val_d;
         shadow_dp_q  <= shadow_dp_d;
         o_an         <= an_d;
         o_seg        <= seg_d;
         o_frame_done <= frame_d;
      end
   end

endmodule
